// File: rtl/alu_seq_n.sv
// Registered, width-parametrised ALU with a start/busy/done handshake.
// Single-cycle arithmetic/logic ops plus a W-iteration unsigned shift-add multiply.
module alu_seq_n #(
  parameter int unsigned W = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         start,
  input  logic [2:0]   Op,
  input  logic [W-1:0] A,
  input  logic [W-1:0] B,
  input  logic         c_in,
  output logic [W-1:0] R,
  output logic         zero,
  output logic         carry,
  output logic         sign,
  output logic         ovf,
  output logic         busy,
  output logic         done
);

  localparam int unsigned CW = $clog2(W + 1);

  typedef enum logic {IDLE, MUL} state_t;

  typedef enum logic [2:0] {
    OP_ADD  = 3'b000,
    OP_SUB  = 3'b001,
    OP_AND  = 3'b010,
    OP_OR   = 3'b011,
    OP_XOR  = 3'b100,
    OP_NOT  = 3'b101,
    OP_MUL  = 3'b110,
    OP_PASS = 3'b111
  } op_t;

  state_t          state, state_n;
  logic [2*W-1:0]  mcand, mcand_n;
  logic [2*W-1:0]  acc, acc_n, acc_add;
  logic [W-1:0]    mplier, mplier_n;
  logic [CW-1:0]   cnt, cnt_n;
  logic [W-1:0]    r_n;
  logic            carry_n, ovf_n, done_n;
  logic [W:0]      sum, diff;

  // zero and sign are pure functions of the registered result
  assign zero = (R == '0);
  assign sign = R[W-1];
  assign busy = (state == MUL);

  always_comb begin
    state_n  = state;
    mcand_n  = mcand;
    mplier_n = mplier;
    acc_n    = acc;
    cnt_n    = cnt;
    r_n      = R;
    carry_n  = carry;
    ovf_n    = ovf;
    done_n   = 1'b0;

    sum     = {1'b0, A} + {1'b0, B} + {{W{1'b0}}, c_in};
    diff    = {1'b0, A} + {1'b0, ~B} + {{W{1'b0}}, 1'b1};
    acc_add = acc + (mplier[0] ? mcand : '0);

    case (state)
      IDLE: begin
        if (start) begin
          if (Op == OP_MUL) begin
            mcand_n  = {{W{1'b0}}, A};
            mplier_n = B;
            acc_n    = '0;
            cnt_n    = CW'(W);
            state_n  = MUL;
          end else begin
            done_n  = 1'b1;
            carry_n = 1'b0;
            ovf_n   = 1'b0;
            case (Op)
              OP_ADD: begin
                r_n     = sum[W-1:0];
                carry_n = sum[W];
                ovf_n   = (A[W-1] == B[W-1]) && (sum[W-1] != A[W-1]);
              end
              OP_SUB: begin
                r_n     = diff[W-1:0];
                carry_n = diff[W];
                ovf_n   = (A[W-1] != B[W-1]) && (diff[W-1] != A[W-1]);
              end
              OP_AND:  r_n = A & B;
              OP_OR:   r_n = A | B;
              OP_XOR:  r_n = A ^ B;
              OP_NOT:  r_n = ~A;
              default: r_n = B;
            endcase
          end
        end
      end
      MUL: begin
        mcand_n  = mcand << 1;
        mplier_n = mplier >> 1;
        acc_n    = acc_add;
        cnt_n    = cnt - CW'(1);
        // last iteration: publish the product formed on this same edge
        if (cnt == CW'(1)) begin
          r_n     = acc_add[W-1:0];
          carry_n = |acc_add[2*W-1:W];
          ovf_n   = 1'b0;
          done_n  = 1'b1;
          state_n = IDLE;
        end
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state  <= IDLE;
      mcand  <= '0;
      mplier <= '0;
      acc    <= '0;
      cnt    <= '0;
      R      <= '0;
      carry  <= 1'b0;
      ovf    <= 1'b0;
      done   <= 1'b0;
    end else begin
      state  <= state_n;
      mcand  <= mcand_n;
      mplier <= mplier_n;
      acc    <= acc_n;
      cnt    <= cnt_n;
      R      <= r_n;
      carry  <= carry_n;
      ovf    <= ovf_n;
      done   <= done_n;
    end
  end

endmodule

// File: tb/tb_alu_seq_n.sv
// Self-checking bench for alu_seq_n at W=4 and W=8: vector table, directed
// multi-cycle sequences, and random ops against an arithmetic reference model.
module tb_alu_seq_n;

  logic       clk = 1'b0;
  logic       rst;
  logic       st4, st8;
  logic [2:0] sop;
  logic [7:0] sa, sb;
  logic       scin;

  logic [3:0] r4;
  logic       z4, c4, s4, o4, b4, d4;
  logic [7:0] r8;
  logic       z8, c8, s8, o8, b8, d8;

  int errors = 0;
  int checks = 0;

  always #5 clk = ~clk;

  alu_seq_n #(.W(4)) dut4 (
    .clk(clk), .reset(rst), .start(st4), .Op(sop), .A(sa[3:0]), .B(sb[3:0]), .c_in(scin),
    .R(r4), .zero(z4), .carry(c4), .sign(s4), .ovf(o4), .busy(b4), .done(d4)
  );

  alu_seq_n #(.W(8)) dut8 (
    .clk(clk), .reset(rst), .start(st8), .Op(sop), .A(sa), .B(sb), .c_in(scin),
    .R(r8), .zero(z8), .carry(c8), .sign(s8), .ovf(o8), .busy(b8), .done(d8)
  );

  typedef struct {
    int w; int op; int a; int b; int cin;
    int r; int z; int c; int s; int o;
    string nm;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", nm, act, exp);
    end
  endtask

  task automatic sample(input int w, output logic [31:0] r,
                        output logic z, c, s, o, bs, dn);
    if (w == 4) begin
      r = {28'b0, r4}; z = z4; c = c4; s = s4; o = o4; bs = b4; dn = d4;
    end else begin
      r = {24'b0, r8}; z = z8; c = c8; s = s8; o = o8; bs = b8; dn = d8;
    end
  endtask

  // Reference: plain integer arithmetic on unsigned/signed interpretations.
  function automatic void model(input int w, input int op, input int a, input int b, input int cin,
                                output int r, output int z, output int c, output int s, output int o);
    longint m  = longint'(1) << w;
    longint xa = (a >= m / 2) ? a - m : a;
    longint xb = (b >= m / 2) ? b - m : b;
    longint full;
    longint ss;
    c = 0; o = 0;
    case (op)
      0: begin full = a + b + cin; c = int'(full >= m); ss = xa + xb + cin;
               o = int'(ss > m / 2 - 1 || ss < -(m / 2)); end
      1: begin full = a - b + m; c = int'(a >= b); ss = xa - xb;
               o = int'(ss > m / 2 - 1 || ss < -(m / 2)); end
      2: full = a & b;
      3: full = a | b;
      4: full = a ^ b;
      5: full = (m - 1) - a;
      6: begin full = longint'(a) * longint'(b); c = int'(full >= m); end
      default: full = b;
    endcase
    r = int'(full % m);
    z = int'(r == 0);
    s = int'(r >= m / 2);
  endfunction

  task automatic do_op(input int w, input int op, input int a, input int b, input int cin,
                       input int er, input int ez, input int ec, input int es, input int eo,
                       input string nm);
    logic [31:0] r;
    logic z, c, s, o, bs, dn;
    int lat;
    @(negedge clk);
    sop = 3'(op); sa = 8'(a); sb = 8'(b); scin = 1'(cin);
    if (w == 4) st4 = 1'b1; else st8 = 1'b1;
    @(negedge clk);
    st4 = 1'b0; st8 = 1'b0;
    sop = 3'($urandom); sa = 8'($urandom); sb = 8'($urandom); scin = 1'($urandom);
    lat = 1;
    sample(w, r, z, c, s, o, bs, dn);
    while (!dn && lat < 20) begin
      @(negedge clk);
      lat++;
      sample(w, r, z, c, s, o, bs, dn);
    end
    chk({nm, ".lat"},   lat, (op == 6) ? w + 1 : 1);
    chk({nm, ".R"},     r, er);
    chk({nm, ".zero"},  32'(z), ez);
    chk({nm, ".carry"}, 32'(c), ec);
    chk({nm, ".sign"},  32'(s), es);
    chk({nm, ".ovf"},   32'(o), eo);
    chk({nm, ".busy"},  32'(bs), 0);
    @(negedge clk);
    sample(w, r, z, c, s, o, bs, dn);
    chk({nm, ".pulse"}, 32'(dn), 0);
  endtask

  vec_t vecs[$];

  initial begin
    logic [31:0] r;
    logic z, c, s, o, bs, dn;
    int er, ez, ec, es, eo;
    int w, op, a, b, cin;
    int npulse;

    vecs.push_back('{4, 0, 4'h7, 4'h1, 0, 4'h8, 0, 0, 1, 1, "add4_ovf"});
    vecs.push_back('{4, 0, 4'hF, 4'h1, 0, 4'h0, 1, 1, 0, 0, "add4_wrap"});
    vecs.push_back('{4, 0, 4'h5, 4'h2, 1, 4'h8, 0, 0, 1, 1, "add4_cin"});
    vecs.push_back('{4, 1, 4'h3, 4'h5, 0, 4'hE, 0, 0, 1, 0, "sub4_borrow"});
    vecs.push_back('{4, 1, 4'h8, 4'h1, 0, 4'h7, 0, 1, 0, 1, "sub4_ovf"});
    vecs.push_back('{4, 6, 4'h5, 4'h3, 0, 4'hF, 0, 0, 1, 0, "mul4_5x3"});
    vecs.push_back('{4, 6, 4'hF, 4'hF, 0, 4'h1, 0, 1, 0, 0, "mul4_fxf"});
    vecs.push_back('{8, 6, 8'h10, 8'h10, 0, 8'h00, 1, 1, 0, 0, "mul8_hi"});
    vecs.push_back('{8, 2, 8'hF0, 8'h3C, 1, 8'h30, 0, 0, 0, 0, "and8"});
    vecs.push_back('{8, 3, 8'hF0, 8'h3C, 1, 8'hFC, 0, 0, 1, 0, "or8"});
    vecs.push_back('{8, 4, 8'hF0, 8'h3C, 1, 8'hCC, 0, 0, 1, 0, "xor8"});
    vecs.push_back('{8, 5, 8'hF0, 8'h3C, 1, 8'h0F, 0, 0, 0, 0, "not8"});
    vecs.push_back('{8, 7, 8'hF0, 8'h3C, 1, 8'h3C, 0, 0, 0, 0, "pass8"});

    rst = 1'b1; st4 = 1'b0; st8 = 1'b0; sop = '0; sa = '0; sb = '0; scin = 1'b0;
    repeat (3) @(negedge clk);
    for (int i = 4; i <= 8; i += 4) begin
      sample(i, r, z, c, s, o, bs, dn);
      chk($sformatf("rst%0d.R", i), r, 0);
      chk($sformatf("rst%0d.zero", i), 32'(z), 1);
      chk($sformatf("rst%0d.carry", i), 32'(c), 0);
      chk($sformatf("rst%0d.flags", i), {29'b0, s, o, bs}, 0);
      chk($sformatf("rst%0d.done", i), 32'(dn), 0);
    end
    rst = 1'b0;

    foreach (vecs[i])
      do_op(vecs[i].w, vecs[i].op, vecs[i].a, vecs[i].b, vecs[i].cin,
            vecs[i].r, vecs[i].z, vecs[i].c, vecs[i].s, vecs[i].o, vecs[i].nm);

    // MUL: start pulsed while busy is ignored, R holds until done
    do_op(4, 7, 0, 9, 0, 9, 0, 0, 1, 0, "pass4_pre");
    @(negedge clk);
    sop = 3'd6; sa = 8'h5; sb = 8'h3; st4 = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      sample(4, r, z, c, s, o, bs, dn);
      chk($sformatf("mulhold%0d.busy", i), 32'(bs), 1);
      chk($sformatf("mulhold%0d.done", i), 32'(dn), 0);
      chk($sformatf("mulhold%0d.R", i), r, 9);
      st4 = (i == 1);
      sop = 3'd0; sa = 8'h1; sb = 8'h1;
    end
    @(negedge clk);
    st4 = 1'b0;
    sample(4, r, z, c, s, o, bs, dn);
    chk("mulhold.done", 32'(dn), 1);
    chk("mulhold.R", r, 4'hF);
    chk("mulhold.busy", 32'(bs), 0);
    @(negedge clk);
    sample(4, r, z, c, s, o, bs, dn);
    chk("mulhold.nodup", 32'(dn), 0);

    // Reset mid-MUL aborts without a done pulse
    @(negedge clk);
    sop = 3'd6; sa = 8'hF; sb = 8'hF; st4 = 1'b1;
    @(negedge clk); st4 = 1'b0;
    @(negedge clk); rst = 1'b1;
    repeat (2) @(negedge clk);
    sample(4, r, z, c, s, o, bs, dn);
    chk("rstmul.R", r, 0);
    chk("rstmul.zero", 32'(z), 1);
    chk("rstmul.busy", 32'(bs), 0);
    chk("rstmul.done", 32'(dn), 0);
    chk("rstmul.cso", {29'b0, c, s, o}, 0);
    rst = 1'b0;
    npulse = 0;
    repeat (8) begin
      @(negedge clk);
      sample(4, r, z, c, s, o, bs, dn);
      if (dn) npulse++;
    end
    chk("rstmul.nopulse", npulse, 0);

    // reset and start on the same edge: start is dropped
    sop = 3'd6; sa = 8'h3; sb = 8'h3; st4 = 1'b1; rst = 1'b1;
    @(negedge clk);
    st4 = 1'b0; rst = 1'b0;
    @(negedge clk);
    sample(4, r, z, c, s, o, bs, dn);
    chk("rststart.busy", 32'(bs), 0);
    chk("rststart.done", 32'(dn), 0);

    // Streaming with start held high: ADD, XOR, MUL, (ignored x4), ADD
    @(negedge clk);
    sop = 3'd0; sa = 8'h3; sb = 8'h4; scin = 1'b0; st4 = 1'b1;
    for (int t = 1; t <= 9; t++) begin
      @(negedge clk);
      sample(4, r, z, c, s, o, bs, dn);
      chk($sformatf("stream%0d.done", t), 32'(dn), (t == 1 || t == 2 || t == 7 || t == 8) ? 1 : 0);
      chk($sformatf("stream%0d.R", t), r, (t == 1) ? 7 : (t <= 6) ? 6 : (t == 7) ? 9 : 2);
      case (t)
        1: begin sop = 3'd4; sa = 8'h5; sb = 8'h3; end
        2: begin sop = 3'd6; sa = 8'h3; sb = 8'h3; end
        3, 4, 5, 6: begin sop = 3'd7; sa = 8'($urandom); sb = 8'($urandom_range(10, 15)); end
        7: begin sop = 3'd0; sa = 8'h1; sb = 8'h1; end
        default: st4 = 1'b0;
      endcase
    end

    // Random ops at both widths against the reference model
    for (int i = 0; i < 150; i++) begin
      w   = ($urandom_range(0, 1) == 0) ? 4 : 8;
      op  = $urandom_range(0, 7);
      a   = $urandom_range(0, (1 << w) - 1);
      b   = $urandom_range(0, (1 << w) - 1);
      cin = $urandom_range(0, 1);
      model(w, op, a, b, cin, er, ez, ec, es, eo);
      do_op(w, op, a, b, cin, er, ez, ec, es, eo,
            $sformatf("rnd%0d_w%0d_op%0d_%0h_%0h_%0d", i, w, op, a, b, cin));
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
